fetch_redirect_ctrl: RTL and testbench
======================================

// Module: fetch_redirect_ctrl
// PURPOSE
//  Owns the fetch PC register (PCR) and sequences IF redirects from branch-select-check results and backend flushes.
//  Each cycle it picks the next fetch VAddr from BTB sequential/predicted PC, a BSC correction, a pending delay-slot target or a commit flush.
//  It also raises kill strobes for the in-flight SCT stage, and enforces "fetch delay slot first, then jump" for branches in slot 3.
//  Sits between the BTB/SCT front stage and BranchSelectCheck, in the IF top level.
// PARAMETERS
//  RESET_PC    32'hBFC0_0000  fetch VAddr after reset
//  PERF_CNT_W  32             width of redirect performance counters
// PORTS
//  clk                        in   1   core clock
//  rst_n                      in   1   asynchronous active-low reset
//  CMT_flush_i                in   1   backend flush (exception/eret/mispredict repair)
//  CMT_flushDest_i            in   32  flush target VAddr
//  FIFO_full_i                in   1   instruction FIFO cannot accept; hold PCR
//  BTB_nextVAddr_i            in   32  BTB-predicted next fetch VAddr for current PCR
//  SCT_valid_i                in   1   SCT stage holds a valid packet this cycle
//  BSC_isDiffRes_w_i          in   1   BPU result differs from BTB result
//  BSC_needDelaySlot_w_i      in   1   BPU-taken branch sits in last enabled slot
//  BSC_DelaySlotIsGetted_w_i  in   1   SCT packet is the requested delay-slot fetch
//  BSC_correctTake_w_i        in   1   BPU final direction
//  BSC_validDest_w_i          in   32  BPU final target
//  BSC_fifthVAddr_w_i         in   32  VAddr after last fetched slot
//  PCR_VAddr_o                out  32  current fetch VAddr
//  PCR_valid_o                out  1   PCR fetch request valid
//  PCR_originEnable_o         out  4   slot enables for current fetch
//  PCR_needDelaySlot_o        out  1   current fetch is a delay-slot-only fetch
//  IF_cancelSCT_o             out  1   kill SCT packet this cycle
//  PERF_bscRedirect_o         out  W   count of BSC redirects
//  PERF_cmtFlush_o            out  W   count of backend flushes
// BEHAVIOUR
//  Reset: PCR=RESET_PC, valid=0, state=RUN, pendDest=0, counters=0, cancel=0, needDelaySlot=0.
//  First cycle after reset: valid=1.
//  originEnable = 4'b1111<<PCR[3:2] in RUN; one-hot(PCR[3:2]) in DS_FETCH.
//  All updates are registered; a redirect takes effect on PCR the next cycle (1-cycle bubble).
//  Priority per cycle: CMT_flush > BSC event (only when SCT_valid_i) > FIFO_full hold > sequential.
//  Sequential: PCR <= BTB_nextVAddr_i.
//  CMT_flush: PCR <= CMT_flushDest_i; state RUN; cancel=1; pendDest dropped; PERF_cmtFlush++.
//   This applies in any state, including on the first cycle after reset.
//  RUN, isDiffRes && !needDelaySlot: PCR <= correctTake ? validDest : fifthVAddr; cancel=1; PERF_bscRedirect++.
//  RUN, needDelaySlot: pendDest <= correctTake ? validDest : fifthVAddr; PCR <= fifthVAddr; state DS_FETCH; cancel=1.
//  DS_FETCH: isDiffRes is ignored (BSC suppresses it).
//   On SCT_valid && DelaySlotIsGetted: PCR <= pendDest; state RUN; no cancel.
//  Redirects are taken even when FIFO_full_i=1. Only sequential advance is held while full.
//  cancel is a 1-cycle pulse, combinational from the selected event; never asserted when SCT_valid_i=0.
//  Counters wrap modulo 2^W. Simultaneous flush and BSC event counts the flush only.
//  Async reset mid-DS_FETCH: returns to RESET_PC and RUN; pendDest is cleared.
// STRUCTURE
//  Shared package/defines:
//   - FRC_STATE encoding (RUN=1'b0, DS_FETCH=1'b1)
//   - RESET_PC macro
//   - existing SINGLE_WORD / INST_NUM widths
//  One natural sub-module: frc_next_pc_mux (priority mux + cancel/event decode), pure combinational.
//  The FSM, PCR, pendDest and counter flops stay in the top module.
// TESTING
//  1. Reset release -> PCR=BFC00000, valid 0 then 1, enable 1111; no stall -> PCR follows BTB_nextVAddr_i.
//  2. SCT_valid, isDiffRes, take=1, dest=80001000 -> cancel pulse; next PCR=80001000; bscRedirect=1.
//  3. needDelaySlot, take=1, dest=80002000, fifth=80000010 -> next PCR=80000010, enable 0001, DS_FETCH.
//     Then DelaySlotIsGetted -> PCR=80002000, state RUN.
//  4. In DS_FETCH, CMT_flush dest=BFC00380 alongside DelaySlotIsGetted -> PCR=BFC00380, RUN, cmtFlush=1, bscRedirect unchanged.
//  5. FIFO_full=1 for 3 cycles -> PCR held; isDiffRes during full still redirects next cycle.
//  6. Assert rst_n low in DS_FETCH -> outputs at reset values immediately; counters forced near 2^W-1 wrap to 0.

Source files
------------

// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared types and constants for the fetch redirect controller.
// The package holds the redirect FSM encoding, the word and slot widths, and the slot-enable helper.
package fetch_redirect_ctrl_pkg;

    localparam int SINGLE_WORD = 32;
    localparam int INST_NUM    = 4;
    localparam logic [SINGLE_WORD-1:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    typedef enum logic {
        RUN      = 1'b0,
        DS_FETCH = 1'b1
    } frcState_e;

    // A delay-slot-only fetch enables just the slot addressed by PC; normal fetch enables it and everything after.
    function automatic logic [INST_NUM-1:0] originEnable(input frcState_e st, input logic [1:0] slot);
        logic [INST_NUM-1:0] base;
        base = '1;
        if (st == DS_FETCH) begin
            base    = '0;
            base[0] = 1'b1;
        end
        return base << slot;
    endfunction

endpackage

// File: rtl/frc_next_pc_mux.sv
// Combinational priority select for the next fetch PC, next FSM state and pending delay-slot target.
// It also decodes the SCT kill strobe and the events that feed the performance counters.
module frc_next_pc_mux
    import fetch_redirect_ctrl_pkg::*;
(
    input  frcState_e              state,
    input  logic                   pcrValid,
    input  logic [SINGLE_WORD-1:0] pcr,
    input  logic [SINGLE_WORD-1:0] pendDest,
    input  logic                   flush,
    input  logic [SINGLE_WORD-1:0] flushDest,
    input  logic                   fifoFull,
    input  logic [SINGLE_WORD-1:0] btbNext,
    input  logic                   sctValid,
    input  logic                   isDiffRes,
    input  logic                   needDelaySlot,
    input  logic                   delaySlotIsGetted,
    input  logic                   correctTake,
    input  logic [SINGLE_WORD-1:0] validDest,
    input  logic [SINGLE_WORD-1:0] fifthVAddr,
    output logic [SINGLE_WORD-1:0] pcrNext,
    output frcState_e              stateNext,
    output logic [SINGLE_WORD-1:0] pendDestNext,
    output logic                   cancel,
    output logic                   bscEvent,
    output logic                   cmtEvent
);

    logic [SINGLE_WORD-1:0] bscTarget;

    assign bscTarget = correctTake ? validDest : fifthVAddr;

    always_comb begin
        pcrNext      = pcr;
        stateNext    = state;
        pendDestNext = pendDest;
        cancel       = 1'b0;
        bscEvent     = 1'b0;
        cmtEvent     = 1'b0;

        if (flush) begin
            pcrNext      = flushDest;
            stateNext    = RUN;
            pendDestNext = '0;
            cancel       = sctValid;
            cmtEvent     = 1'b1;
        end else if (sctValid && state == RUN && needDelaySlot) begin
            // Fetch the delay slot alone first; the real target waits in pendDest.
            pendDestNext = bscTarget;
            pcrNext      = fifthVAddr;
            stateNext    = DS_FETCH;
            cancel       = 1'b1;
        end else if (sctValid && state == RUN && isDiffRes) begin
            pcrNext  = bscTarget;
            cancel   = 1'b1;
            bscEvent = 1'b1;
        end else if (sctValid && state == DS_FETCH && delaySlotIsGetted) begin
            pcrNext      = pendDest;
            stateNext    = RUN;
            pendDestNext = '0;
        end else if (state == RUN && pcrValid && !fifoFull) begin
            // The first request after reset must fetch RESET_PC itself, so advance only once valid.
            pcrNext = btbNext;
        end
        // In DS_FETCH the delay-slot request is held until SCT reports it fetched.
    end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC register and IF redirect sequencer: holds PCR, the redirect FSM, the pending
// delay-slot target and the redirect performance counters around the next-PC mux.
module fetch_redirect_ctrl
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter logic [SINGLE_WORD-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int                     PERF_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   CMT_flush_i,
    input  logic [SINGLE_WORD-1:0] CMT_flushDest_i,
    input  logic                   FIFO_full_i,
    input  logic [SINGLE_WORD-1:0] BTB_nextVAddr_i,
    input  logic                   SCT_valid_i,
    input  logic                   BSC_isDiffRes_w_i,
    input  logic                   BSC_needDelaySlot_w_i,
    input  logic                   BSC_DelaySlotIsGetted_w_i,
    input  logic                   BSC_correctTake_w_i,
    input  logic [SINGLE_WORD-1:0] BSC_validDest_w_i,
    input  logic [SINGLE_WORD-1:0] BSC_fifthVAddr_w_i,
    output logic [SINGLE_WORD-1:0] PCR_VAddr_o,
    output logic                   PCR_valid_o,
    output logic [INST_NUM-1:0]    PCR_originEnable_o,
    output logic                   PCR_needDelaySlot_o,
    output logic                   IF_cancelSCT_o,
    output logic [PERF_CNT_W-1:0]  PERF_bscRedirect_o,
    output logic [PERF_CNT_W-1:0]  PERF_cmtFlush_o
);

    logic [SINGLE_WORD-1:0] pcrReg, pcrNext;
    logic [SINGLE_WORD-1:0] pendDestReg, pendDestNext;
    frcState_e              stateReg, stateNext;
    logic                   validReg;
    logic [PERF_CNT_W-1:0]  bscCntReg, cmtCntReg;
    logic                   bscEvent, cmtEvent;

    frc_next_pc_mux u_mux (
        .state             (stateReg),
        .pcrValid          (validReg),
        .pcr               (pcrReg),
        .pendDest          (pendDestReg),
        .flush             (CMT_flush_i),
        .flushDest         (CMT_flushDest_i),
        .fifoFull          (FIFO_full_i),
        .btbNext           (BTB_nextVAddr_i),
        .sctValid          (SCT_valid_i),
        .isDiffRes         (BSC_isDiffRes_w_i),
        .needDelaySlot     (BSC_needDelaySlot_w_i),
        .delaySlotIsGetted (BSC_DelaySlotIsGetted_w_i),
        .correctTake       (BSC_correctTake_w_i),
        .validDest         (BSC_validDest_w_i),
        .fifthVAddr        (BSC_fifthVAddr_w_i),
        .pcrNext           (pcrNext),
        .stateNext         (stateNext),
        .pendDestNext      (pendDestNext),
        .cancel            (IF_cancelSCT_o),
        .bscEvent          (bscEvent),
        .cmtEvent          (cmtEvent)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcrReg      <= RESET_PC;
            pendDestReg <= '0;
            stateReg    <= RUN;
            validReg    <= 1'b0;
        end else begin
            pcrReg      <= pcrNext;
            pendDestReg <= pendDestNext;
            stateReg    <= stateNext;
            validReg    <= 1'b1;
        end
    end

    // The mux only raises bscEvent when no flush is present, so a coincident pair counts once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bscCntReg <= '0;
            cmtCntReg <= '0;
        end else begin
            if (bscEvent) bscCntReg <= bscCntReg + PERF_CNT_W'(1);
            if (cmtEvent) cmtCntReg <= cmtCntReg + PERF_CNT_W'(1);
        end
    end

    assign PCR_VAddr_o         = pcrReg;
    assign PCR_valid_o         = validReg;
    assign PCR_originEnable_o  = originEnable(stateReg, pcrReg[3:2]);
    assign PCR_needDelaySlot_o = (stateReg == DS_FETCH);
    assign PERF_bscRedirect_o  = bscCntReg;
    assign PERF_cmtFlush_o     = cmtCntReg;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl; narrow counters make the wrap reachable in a few flushes.
module tb_fetch_redirect_ctrl;

    localparam int W = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, fifoFull, sctValid, isDiff, needDs, dsGot, take;
    logic [31:0] flushDest, btbNext, validDest, fifthVAddr;
    logic [31:0] pcr;
    logic        pcrValid, needDsO, cancel;
    logic [3:0]  enable;
    logic [W-1:0] bscCnt, cmtCnt;

    int checks   = 0;
    int failures = 0;

    fetch_redirect_ctrl #(.RESET_PC(32'hBFC0_0000), .PERF_CNT_W(W)) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .CMT_flush_i               (flush),
        .CMT_flushDest_i           (flushDest),
        .FIFO_full_i               (fifoFull),
        .BTB_nextVAddr_i           (btbNext),
        .SCT_valid_i               (sctValid),
        .BSC_isDiffRes_w_i         (isDiff),
        .BSC_needDelaySlot_w_i     (needDs),
        .BSC_DelaySlotIsGetted_w_i (dsGot),
        .BSC_correctTake_w_i       (take),
        .BSC_validDest_w_i         (validDest),
        .BSC_fifthVAddr_w_i        (fifthVAddr),
        .PCR_VAddr_o               (pcr),
        .PCR_valid_o               (pcrValid),
        .PCR_originEnable_o        (enable),
        .PCR_needDelaySlot_o       (needDsO),
        .IF_cancelSCT_o            (cancel),
        .PERF_bscRedirect_o        (bscCnt),
        .PERF_cmtFlush_o           (cmtCnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        flush = 0; fifoFull = 0; sctValid = 0; isDiff = 0; needDs = 0; dsGot = 0; take = 0;
        flushDest = '0; validDest = '0; fifthVAddr = '0;
    endtask

    task automatic test_reset;
        rst_n = 0; btbNext = 32'hBFC0_0010;
        clear_inputs();
        repeat (2) tick();
        checks++; if (pcr !== 32'hBFC0_0000) begin failures++; $display("FAIL rst_pcr got=%h exp=bfc00000", pcr); end
        checks++; if (pcrValid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", pcrValid); end
        checks++; if (enable !== 4'b1111) begin failures++; $display("FAIL rst_enable got=%b exp=1111", enable); end
        checks++; if ({cancel, needDsO} !== 2'b00) begin failures++; $display("FAIL rst_cancel_ds got=%b exp=00", {cancel, needDsO}); end
        checks++; if ({bscCnt, cmtCnt} !== '0) begin failures++; $display("FAIL rst_counters got=%h/%h exp=0/0", bscCnt, cmtCnt); end
        rst_n = 1;
        tick();
        checks++; if (pcrValid !== 1'b1) begin failures++; $display("FAIL first_valid got=%b exp=1", pcrValid); end
        checks++; if (pcr !== 32'hBFC0_0000) begin failures++; $display("FAIL first_pcr got=%h exp=bfc00000", pcr); end
        tick();
        checks++; if (pcr !== 32'hBFC0_0010) begin failures++; $display("FAIL seq_pcr got=%h exp=bfc00010", pcr); end
        btbNext = 32'hBFC0_0014;
        tick();
        checks++; if (pcr !== 32'hBFC0_0014) begin failures++; $display("FAIL seq_pcr2 got=%h exp=bfc00014", pcr); end
        checks++; if (enable !== 4'b1110) begin failures++; $display("FAIL seq_enable got=%b exp=1110", enable); end
        $display("txn reset/sequential pcr=%h enable=%b", pcr, enable);
    endtask

    task automatic test_bsc_redirect;
        sctValid = 1; isDiff = 1; take = 1; validDest = 32'h8000_1000; fifthVAddr = 32'hBFC0_0020;
        #1;
        checks++; if (cancel !== 1'b1) begin failures++; $display("FAIL bsc_cancel got=%b exp=1", cancel); end
        tick();
        clear_inputs();
        #1;
        checks++; if (cancel !== 1'b0) begin failures++; $display("FAIL bsc_cancel_pulse got=%b exp=0", cancel); end
        checks++; if (pcr !== 32'h8000_1000) begin failures++; $display("FAIL bsc_taken_pcr got=%h exp=80001000", pcr); end
        checks++; if (bscCnt !== 3'd1) begin failures++; $display("FAIL bsc_cnt1 got=%0d exp=1", bscCnt); end
        sctValid = 1; isDiff = 1; take = 0; validDest = 32'h8000_9000; fifthVAddr = 32'h8000_1010;
        tick();
        clear_inputs();
        checks++; if (pcr !== 32'h8000_1010) begin failures++; $display("FAIL bsc_nottaken_pcr got=%h exp=80001010", pcr); end
        checks++; if (bscCnt !== 3'd2) begin failures++; $display("FAIL bsc_cnt2 got=%0d exp=2", bscCnt); end
        $display("txn bsc_redirect pcr=%h bsc=%0d", pcr, bscCnt);
    endtask

    task automatic test_delay_slot;
        sctValid = 1; needDs = 1; take = 1; validDest = 32'h8000_2000; fifthVAddr = 32'h8000_0010;
        #1;
        checks++; if (cancel !== 1'b1) begin failures++; $display("FAIL ds_cancel got=%b exp=1", cancel); end
        tick();
        clear_inputs();
        checks++; if (pcr !== 32'h8000_0010) begin failures++; $display("FAIL ds_pcr got=%h exp=80000010", pcr); end
        checks++; if (enable !== 4'b0001) begin failures++; $display("FAIL ds_enable got=%b exp=0001", enable); end
        checks++; if (needDsO !== 1'b1) begin failures++; $display("FAIL ds_flag got=%b exp=1", needDsO); end
        checks++; if (bscCnt !== 3'd2) begin failures++; $display("FAIL ds_bsc_cnt got=%0d exp=2", bscCnt); end
        tick();
        checks++; if (pcr !== 32'h8000_0010) begin failures++; $display("FAIL ds_hold got=%h exp=80000010", pcr); end
        sctValid = 1; dsGot = 1; isDiff = 1;
        #1;
        checks++; if (cancel !== 1'b0) begin failures++; $display("FAIL ds_got_cancel got=%b exp=0", cancel); end
        tick();
        clear_inputs();
        checks++; if (pcr !== 32'h8000_2000) begin failures++; $display("FAIL ds_target got=%h exp=80002000", pcr); end
        checks++; if ({needDsO, enable} !== 5'b0_1111) begin failures++; $display("FAIL ds_run got=%b exp=01111", {needDsO, enable}); end
        $display("txn delay_slot pcr=%h", pcr);
    endtask

    task automatic test_flush_in_ds;
        sctValid = 1; needDs = 1; take = 1; validDest = 32'h8000_3000; fifthVAddr = 32'h8000_2010;
        tick();
        clear_inputs();
        checks++; if (needDsO !== 1'b1) begin failures++; $display("FAIL fds_enter got=%b exp=1", needDsO); end
        flush = 1; flushDest = 32'hBFC0_0380; sctValid = 1; dsGot = 1; isDiff = 1;
        #1;
        checks++; if (cancel !== 1'b1) begin failures++; $display("FAIL fds_cancel got=%b exp=1", cancel); end
        tick();
        clear_inputs();
        checks++; if (pcr !== 32'hBFC0_0380) begin failures++; $display("FAIL fds_pcr got=%h exp=bfc00380", pcr); end
        checks++; if (needDsO !== 1'b0) begin failures++; $display("FAIL fds_state got=%b exp=0", needDsO); end
        checks++; if ({cmtCnt, bscCnt} !== {3'd1, 3'd2}) begin failures++; $display("FAIL fds_counts got=%0d/%0d exp=1/2", cmtCnt, bscCnt); end
        $display("txn flush_in_ds pcr=%h cmt=%0d", pcr, cmtCnt);
    endtask

    task automatic test_fifo_full;
        fifoFull = 1; btbNext = 32'h9000_0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (pcr !== 32'hBFC0_0380) begin failures++; $display("FAIL full_hold%0d got=%h exp=bfc00380", i, pcr); end
        end
        sctValid = 1; isDiff = 1; take = 0; fifthVAddr = 32'h8000_4000;
        #1;
        checks++; if (cancel !== 1'b1) begin failures++; $display("FAIL full_cancel got=%b exp=1", cancel); end
        tick();
        checks++; if (pcr !== 32'h8000_4000) begin failures++; $display("FAIL full_redirect got=%h exp=80004000", pcr); end
        checks++; if (bscCnt !== 3'd3) begin failures++; $display("FAIL full_bsc_cnt got=%0d exp=3", bscCnt); end
        clear_inputs();
        btbNext = 32'h9000_0040;
        tick();
        checks++; if (pcr !== 32'h9000_0040) begin failures++; $display("FAIL full_release got=%h exp=90000040", pcr); end
        $display("txn fifo_full pcr=%h", pcr);
    endtask

    task automatic test_wrap_and_reset;
        flush = 1; flushDest = 32'hA000_0000; sctValid = 1; isDiff = 1; take = 1; validDest = 32'h8000_5000;
        tick();
        clear_inputs();
        checks++; if ({pcr, cmtCnt, bscCnt} !== {32'hA000_0000, 3'd2, 3'd3}) begin failures++; $display("FAIL both_evt got=%h/%0d/%0d exp=a0000000/2/3", pcr, cmtCnt, bscCnt); end
        flush = 1; flushDest = 32'hA000_0040;
        #1;
        checks++; if (cancel !== 1'b0) begin failures++; $display("FAIL flush_nosct_cancel got=%b exp=0", cancel); end
        repeat (5) tick();
        checks++; if (cmtCnt !== 3'd7) begin failures++; $display("FAIL cmt_max got=%0d exp=7", cmtCnt); end
        tick();
        checks++; if (cmtCnt !== 3'd0) begin failures++; $display("FAIL cmt_wrap got=%0d exp=0", cmtCnt); end
        clear_inputs();
        sctValid = 1; needDs = 1; take = 1; validDest = 32'h8000_6000; fifthVAddr = 32'h8000_5010;
        tick();
        clear_inputs();
        checks++; if (needDsO !== 1'b1) begin failures++; $display("FAIL rst_ds_enter got=%b exp=1", needDsO); end
        #2 rst_n = 0;
        #1;
        checks++; if ({pcr, pcrValid, needDsO, enable} !== {32'hBFC0_0000, 1'b0, 1'b0, 4'b1111}) begin failures++; $display("FAIL async_rst got=%h/%b/%b/%b exp=bfc00000/0/0/1111", pcr, pcrValid, needDsO, enable); end
        checks++; if ({bscCnt, cmtCnt} !== '0) begin failures++; $display("FAIL async_rst_cnt got=%0d/%0d exp=0/0", bscCnt, cmtCnt); end
        tick();
        rst_n = 1; btbNext = 32'hBFC0_0020;
        tick();
        sctValid = 1; dsGot = 1;
        tick();
        clear_inputs();
        checks++; if (pcr !== 32'hBFC0_0020) begin failures++; $display("FAIL post_rst_run got=%h exp=bfc00020", pcr); end
        $display("txn wrap_and_reset pcr=%h", pcr);
    endtask

    initial begin
        test_reset();
        test_bsc_redirect();
        test_delay_slot();
        test_flush_in_ds();
        test_fifo_full();
        test_wrap_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
